// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if
//   Bundles the two read ports and the ROM-side signals of the sprite ROM
//   arbiter.
//   disp_*  : display renderer read port (req/addr in, gnt/rvalid/rdata out)
//   aux_*   : auxiliary reader read port (same shape as disp_*)
//   rom_*   : ROM address out, ROM data in
//   modport slave  : the arbiter's view
//   modport master : the requester / ROM side view
interface sprite_rom_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_gnt;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;

    modport slave (
        input  disp_req, disp_addr, aux_req, aux_addr, rom_q,
        output disp_gnt, disp_rvalid, disp_rdata,
        output aux_gnt, aux_rvalid, aux_rdata, rom_addr
    );

    modport master (
        output disp_req, disp_addr, aux_req, aux_addr, rom_q,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  aux_gnt, aux_rvalid, aux_rdata, rom_addr
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares a single-port sprite ROM between the display renderer (disp,
//   fixed priority) and an auxiliary reader (aux). A wait counter forces an
//   aux grant after MAX_WAIT consecutive blocked cycles. Accepted reads are
//   tracked through a tag pipeline and returned, registered, on the port
//   that issued them, in accept order.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : sprite_rom_arbiter_if.slave (read ports and ROM interface)
module sprite_rom_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 8
) (
    input logic                 clk,
    input logic                 rst,
    sprite_rom_arbiter_if.slave bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic              force_aux;
    logic              disp_gnt;
    logic              aux_gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] rom_addr_c;

    // Stage i holds the read accepted i+1 edges ago; the last stage lines up
    // with rom_q carrying that read's data.
    logic [ROM_LAT:0]  tag_vld;
    logic [ROM_LAT:0]  tag_aux;

    logic              disp_rvalid_q;
    logic              aux_rvalid_q;
    logic [DATA_W-1:0] disp_rdata_q;
    logic [DATA_W-1:0] aux_rdata_q;

    always_comb begin
        force_aux  = bus.aux_req && (wait_cnt == WAIT_TOP);
        disp_gnt   = bus.disp_req && !force_aux;
        aux_gnt    = bus.aux_req && (!bus.disp_req || force_aux);
        any_gnt    = disp_gnt || aux_gnt;
        rom_addr_c = last_addr;
        if (aux_gnt)
            rom_addr_c = bus.aux_addr;
        else if (disp_gnt)
            rom_addr_c = bus.disp_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt      <= '0;
            last_addr     <= '0;
            tag_vld       <= '0;
            tag_aux       <= '0;
            disp_rvalid_q <= 1'b0;
            aux_rvalid_q  <= 1'b0;
            disp_rdata_q  <= '0;
            aux_rdata_q   <= '0;
        end else begin
            if (!bus.aux_req || aux_gnt)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_TOP)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (any_gnt)
                last_addr <= rom_addr_c;

            tag_vld <= {tag_vld[ROM_LAT-1:0], any_gnt};
            tag_aux <= {tag_aux[ROM_LAT-1:0], aux_gnt};

            disp_rvalid_q <= tag_vld[ROM_LAT] && !tag_aux[ROM_LAT];
            aux_rvalid_q  <= tag_vld[ROM_LAT] &&  tag_aux[ROM_LAT];

            if (tag_vld[ROM_LAT]) begin
                if (tag_aux[ROM_LAT])
                    aux_rdata_q <= bus.rom_q;
                else
                    disp_rdata_q <= bus.rom_q;
            end
        end
    end

    // Grants are gated here only, so no state depends on rst combinationally.
    assign bus.disp_gnt    = disp_gnt && !rst;
    assign bus.aux_gnt     = aux_gnt && !rst;
    assign bus.rom_addr    = rom_addr_c;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.aux_rvalid  = aux_rvalid_q;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.aux_rdata   = aux_rdata_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int ROM_LAT  = 1;
    localparam int MAX_WAIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return {17'h0, a};
    endfunction

    // ROM: samples rom_addr at an edge, data usable ROM_LAT edges later.
    logic [DATA_W-1:0] rom_pipe [0:ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_f(bus.rom_addr);
        for (int i = 1; i <= ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_q = rom_pipe[ROM_LAT];

    // Reference model state
    typedef struct {
        bit                aux;
        logic [ADDR_W-1:0] addr;
        int                due;
    } rd_t;
    rd_t               pend[$];
    int                edge_cnt = 0;
    int                aux_blocked = 0;
    logic [ADDR_W-1:0] exp_last = '0;
    logic [DATA_W-1:0] exp_disp_rdata = '0;
    logic [DATA_W-1:0] exp_aux_rdata = '0;
    bit                last_dg, last_ag;
    int                obs_disp_resp = 0;
    int                obs_aux_resp = 0;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        aux_blocked    = 0;
        exp_last       = '0;
        exp_disp_rdata = '0;
        exp_aux_rdata  = '0;
    endtask

    // Responses registered at the most recent edge.
    task automatic check_resp();
        bit  e_d = 1'b0;
        bit  e_a = 1'b0;
        rd_t r;
        if (pend.size() > 0 && pend[0].due == edge_cnt) begin
            r = pend.pop_front();
            if (r.aux) begin
                e_a = 1'b1;
                exp_aux_rdata = rom_f(r.addr);
            end else begin
                e_d = 1'b1;
                exp_disp_rdata = rom_f(r.addr);
            end
        end
        chk("disp_rvalid", bus.disp_rvalid, e_d);
        chk("aux_rvalid", bus.aux_rvalid, e_a);
        chk("disp_rdata", bus.disp_rdata, exp_disp_rdata);
        chk("aux_rdata", bus.aux_rdata, exp_aux_rdata);
        if (bus.disp_rvalid) obs_disp_resp++;
        if (bus.aux_rvalid) obs_aux_resp++;
    endtask

    // One clock cycle: check responses, drive requests, check grants and
    // rom_addr, then take the edge.
    task automatic drive_cycle(input bit dr, input logic [ADDR_W-1:0] da,
                               input bit ar, input logic [ADDR_W-1:0] aa);
        bit                m_force, m_dg, m_ag;
        logic [ADDR_W-1:0] m_addr;
        @(negedge clk);
        check_resp();
        bus.disp_req  = dr;
        bus.disp_addr = da;
        bus.aux_req   = ar;
        bus.aux_addr  = aa;
        #1;
        m_force = ar && (aux_blocked >= MAX_WAIT);
        m_dg    = dr && !m_force;
        m_ag    = ar && (!dr || m_force);
        m_addr  = m_ag ? aa : (m_dg ? da : exp_last);
        chk("disp_gnt", bus.disp_gnt, m_dg);
        chk("aux_gnt", bus.aux_gnt, m_ag);
        chk("rom_addr", bus.rom_addr, m_addr);
        if (m_dg || m_ag) begin
            pend.push_back('{aux: m_ag, addr: m_addr, due: edge_cnt + 1 + ROM_LAT + 1});
            exp_last = m_addr;
        end
        aux_blocked = (ar && !m_ag) ? aux_blocked + 1 : 0;
        last_dg = m_dg;
        last_ag = m_ag;
        @(posedge clk);
        edge_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, '0, 1'b0, '0);
    endtask

    // Asynchronous reset asserted mid-cycle with both requests active.
    task automatic reset_mid();
        #3;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 15'($urandom);
        bus.aux_req   = 1'b1;
        bus.aux_addr  = 15'($urandom);
        rst = 1'b1;
        #1;
        chk("rst_disp_gnt", bus.disp_gnt, 1'b0);
        chk("rst_aux_gnt", bus.aux_gnt, 1'b0);
        chk("rst_disp_rvalid", bus.disp_rvalid, 1'b0);
        chk("rst_aux_rvalid", bus.aux_rvalid, 1'b0);
        chk("rst_disp_rdata", bus.disp_rdata, 32'h0);
        chk("rst_aux_rdata", bus.aux_rdata, 32'h0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.disp_req = 1'b0;
        bus.aux_req  = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_rom_addr", bus.rom_addr, 15'h0);
        @(posedge clk);
        edge_cnt++;
    endtask

    initial begin
        int                base_d, base_a;
        logic [31:0]       aux_slots;
        bit                rd_pend, ra_pend;
        logic [ADDR_W-1:0] rd_addr, ra_addr;
        logic [ADDR_W-1:0] a_hold;

        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.aux_req   = 1'b0;
        bus.aux_addr  = '0;

        reset_mid();

        // Single disp read
        base_d = obs_disp_resp;
        drive_cycle(1'b1, 15'h0010, 1'b0, '0);
        idle(4);
        chk("single_disp_count", obs_disp_resp - base_d, 1);
        chk("single_disp_data", bus.disp_rdata, 32'h0000_0010);

        // Collision: disp wins, aux follows
        drive_cycle(1'b1, 15'h0100, 1'b1, 15'h0200);
        chk("coll_first_disp", last_dg, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 15'h0200);
        idle(4);
        chk("coll_aux_data", bus.aux_rdata, 32'h0000_0200);

        // Back-to-back stream 0..15
        base_d = obs_disp_resp;
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 15'(i), 1'b0, '0);
        idle(5);
        chk("b2b_count", obs_disp_resp - base_d, 16);
        chk("b2b_rom_addr_hold", bus.rom_addr, 15'd15);

        // Starvation: both held for 30 cycles
        base_d = obs_disp_resp;
        base_a = obs_aux_resp;
        aux_slots = '0;
        a_hold = 15'($urandom);
        for (int c = 1; c <= 30; c++) begin
            drive_cycle(1'b1, 15'($urandom), 1'b1, a_hold);
            if (bus.aux_gnt === 1'b1 || last_ag) aux_slots[c] = last_ag;
            if (last_ag) a_hold = 15'($urandom);
        end
        idle(5);
        chk("starve_aux_slots", aux_slots, 32'h0804_0200);
        chk("starve_disp_count", obs_disp_resp - base_d, 27);
        chk("starve_aux_count", obs_aux_resp - base_a, 3);

        // Reset with a read in flight
        base_d = obs_disp_resp;
        drive_cycle(1'b1, 15'h0042, 1'b0, '0);
        reset_mid();
        idle(5);
        chk("midflight_no_resp", obs_disp_resp - base_d, 0);
        chk("midflight_rdata", bus.disp_rdata, 32'h0);

        // Randomized traffic; requesters hold until granted or cancel
        rd_pend = 1'b0;
        ra_pend = 1'b0;
        rd_addr = '0;
        ra_addr = '0;
        for (int n = 0; n < 400; n++) begin
            if (!rd_pend) begin
                rd_pend = ($urandom_range(0, 99) < 60);
                rd_addr = 15'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                rd_pend = 1'b0;
            end
            if (!ra_pend) begin
                ra_pend = ($urandom_range(0, 99) < 40);
                ra_addr = 15'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                ra_pend = 1'b0;
            end
            drive_cycle(rd_pend, rd_addr, ra_pend, ra_addr);
            if (last_dg) rd_pend = 1'b0;
            if (last_ag) ra_pend = 1'b0;
            if (n == 200) begin
                reset_mid();
                rd_pend = 1'b0;
                ra_pend = 1'b0;
            end
        end
        idle(6);
        chk("drain_empty", pend.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the single-port sprite ROM (15-bit address, 32-bit word) between two readers: the per-pixel display renderer (port "disp") and an auxiliary reader (port "aux"), e.g. a sprite-cache preloader or debug reader.
- Fixed priority goes to disp. A wait counter guarantees aux a slot after MAX_WAIT blocked cycles.
- Tracks in-flight reads and returns each word, registered, on the port that issued it.
- Sits between the drawing logic / color mapper and the ROM instance.

Parameters:
- ADDR_W, 15, ROM address width.
- DATA_W, 32, ROM data width.
- ROM_LAT, 1, cycles from the clock edge that samples rom_addr to rom_q being valid. Legal range 1..4.
- MAX_WAIT, 8, consecutive blocked aux cycles before aux is forced. Must be ≥1.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display request accepted at this clock edge.
- disp_rvalid  out  1  disp_rdata valid (1-cycle pulse per accepted read).
- disp_rdata  out  DATA_W  display read data.
- aux_req  in  1  auxiliary read request.
- aux_addr  in  ADDR_W  auxiliary read address.
- aux_gnt  out  1  auxiliary request accepted at this clock edge.
- aux_rvalid  out  1  aux_rdata valid.
- aux_rdata  out  DATA_W  auxiliary read data.
- rom_addr  out  ADDR_W  address to the ROM.
- rom_q  in  DATA_W  ROM output data.

Behaviour:
- Reset: asynchronous and active-high (fixed). While Reset is high and after it is released:
  - all rvalid = 0, all rdata = 0;
  - wait_cnt = 0, in-flight tag pipeline cleared, last_addr = 0;
  - disp_gnt = aux_gnt = 0 while Reset is high.
- force_aux = aux_req && (wait_cnt == MAX_WAIT).
- Grants (combinational from the current-cycle req and wait_cnt; no registered handshake):
  - disp_gnt = disp_req && !force_aux.
  - aux_gnt = aux_req && (!disp_req || force_aux).
  - At most one grant per cycle.
- Accept: a request is accepted at the rising edge where req && gnt is high. Requesters hold req/addr until granted. Dropping req before grant is legal and cancels the request.
- rom_addr:
  - Granted port's address when any grant is high.
  - Otherwise last_addr (the address of the last accepted read), so the ROM input stays stable when idle.
  - last_addr updates on each accept.
- Tag pipeline:
  - ROM_LAT+1 stages, each holding {valid, port}.
  - Stage 0 loads at each edge: valid = any grant, port = aux_gnt. Other stages shift.
  - When the final stage is valid, the corresponding rdata is registered from rom_q and its rvalid is high for that cycle only.
- Latency: rvalid rises after edge E0+ROM_LAT+1, where E0 is the accept edge. With ROM_LAT=1 this is 2 edges after accept.
- Throughput: one read per cycle. Responses come back in accept order with no bubbles.
- rdata holds its last value while rvalid is low. Each port's rdata changes only on its own responses.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - Clears on aux accept, or when aux_req is low.
  - Increments by 1 when aux_req is high and aux_gnt is low.
  - Saturates at MAX_WAIT.
- Continuous contention: disp and aux both holding req gives aux exactly 1 grant every MAX_WAIT+1 cycles; disp gets the rest.
- Simultaneous requests with wait_cnt < MAX_WAIT: disp wins and aux wait_cnt increments.
- Reset mid-operation: in-flight reads are discarded. No rvalid is asserted for any read accepted before Reset.
- No internal buffering of requests: a blocked requester stalls. The arbiter never drops an accepted read.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle with random req activity → all gnt, rvalid and rdata read 0 immediately; rom_addr = 0 after release with no req.
- Single disp read: ROM model q = {17'h0, addr} with ROM_LAT=1; disp_req for 1 cycle, addr 0x0010 → disp_gnt=1 that cycle; disp_rvalid pulses 1 cycle, 2 edges after accept, with disp_rdata=0x00000010; aux_rvalid stays 0.
- Collision: disp_req (0x0100) and aux_req (0x0200) in the same cycle → disp_gnt=1, aux_gnt=0; disp drops next cycle → aux_gnt=1 then; responses are disp 0x100 followed by aux 0x200 on consecutive cycles.
- Starvation: MAX_WAIT=8, both req held for 30 cycles → aux_gnt high in cycles 9, 18, 27 only (with disp_gnt low in those cycles); 27 disp and 3 aux responses, each with correct data.
- Back-to-back: disp addresses 0..15 on every cycle, no aux → 16 consecutive disp_rvalid cycles with data 0..15 in order; rom_addr holds 15 after the stream ends.
- Reset mid-flight: accept disp read 0x0042, then assert Reset on the next cycle and release it → no disp_rvalid afterwards; disp_rdata stays 0.
